// File: rtl/timer_pkg.sv
// Shared types and helpers for the lap timer.
//   state_e       : timer control state (IDLE / RUN / STOP), 2-bit
//   DEF_*         : default prescaler and microsecond-per-millisecond ratios
//   cnt_width()   : bits needed to hold a modulo-N count (0..N-1)
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  localparam int DEF_PRESCALE_DIV = 125;
  localparam int DEF_US_PER_MS    = 1000;

  // A modulo-N counter spans 0..N-1; never return less than one bit.
  function automatic int cnt_width(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Modulo-N counter with enable and synchronous zero.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   i_en    : advance the count this cycle
//   i_zero  : force the count to 0 (wins over i_en)
//   o_tick  : high for the cycle in which an enabled count sits at N-1;
//             the count wraps to 0 on the following edge
module tick_gen
  import timer_pkg::*;
#(
  parameter int N = DEF_PRESCALE_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_en,
  input  logic i_zero,
  output logic o_tick
);

  localparam int           W    = cnt_width(N);
  localparam logic [W-1:0] LAST = W'(N - 1);
  localparam logic [W-1:0] ONE  = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         at_last;

  assign at_last = (cnt_q == LAST);
  assign o_tick  = i_en && at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (i_zero) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = at_last ? '0 : (cnt_q + ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lap_timer.sv
// Millisecond lap/reaction timer.
//   clk          : system clock, rising edge
//   rst          : asynchronous active-low reset
//   i_start      : start (IDLE->RUN, STOP->RUN)
//   i_stop       : stop (RUN->STOP) with automatic capture
//   i_clear      : synchronous clear to IDLE, highest priority
//   i_capture    : lap capture request in RUN or STOP
//   o_timer_ms   : live millisecond count
//   o_running    : high while in RUN
//   o_ovf        : sticky millisecond overflow flag
//   o_cap_ms     : last captured millisecond value
//   o_cap_valid  : one-cycle pulse coincident with an o_cap_ms update
//   o_state      : current control state, for observation
// Control priority each cycle: i_clear > i_stop > i_start.
// The clock is divided by PRESCALE_DIV into microsecond ticks, which are
// divided by US_PER_MS into millisecond ticks that advance o_timer_ms.
module lap_timer
  import timer_pkg::*;
#(
  parameter int PRESCALE_DIV = DEF_PRESCALE_DIV,
  parameter int US_PER_MS    = DEF_US_PER_MS,
  parameter int MS_W         = 15,
  parameter int SATURATE     = 1,
  parameter int RESUME       = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_stop,
  input  logic            i_clear,
  input  logic            i_capture,
  output logic [MS_W-1:0] o_timer_ms,
  output logic            o_running,
  output logic            o_ovf,
  output logic [MS_W-1:0] o_cap_ms,
  output logic            o_cap_valid,
  output state_e          o_state
);

  localparam logic [MS_W-1:0] MS_MAX = '1;
  localparam logic [MS_W-1:0] MS_ONE = MS_W'(1);
  localparam bit              RESTART_ZEROES = (RESUME == 0);
  localparam bit              HOLD_AT_MAX    = (SATURATE != 0);

  state_e          state_q, state_d;
  logic [MS_W-1:0] ms_q, ms_d;
  logic            ovf_q, ovf_d;
  logic [MS_W-1:0] cap_ms_q, cap_ms_d;
  logic            cap_valid_q, cap_valid_d;

  logic running;
  logic restart;
  logic zero_cnt;
  logic us_tick;
  logic ms_tick;
  logic cap_req;

  assign running = (state_q == RUN);

  // i_stop has no meaning in STOP, so it does not block a start there.
  assign restart  = (state_q == STOP) && i_start && !i_clear;
  assign zero_cnt = i_clear || (restart && RESTART_ZEROES);

  tick_gen #(.N(PRESCALE_DIV)) u_prescaler (
    .clk    (clk),
    .rst_n  (rst),
    .i_en   (running),
    .i_zero (zero_cnt),
    .o_tick (us_tick)
  );

  tick_gen #(.N(US_PER_MS)) u_us_stage (
    .clk    (clk),
    .rst_n  (rst),
    .i_en   (us_tick),
    .i_zero (zero_cnt),
    .o_tick (ms_tick)
  );

  // Stop and capture in the same cycle collapse into one capture.
  assign cap_req = !i_clear &&
                   ((running && (i_stop || i_capture)) ||
                    ((state_q == STOP) && i_capture));

  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start) state_d = RUN;
        RUN:     if (i_stop)  state_d = STOP;
        STOP:    if (i_start) state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    ms_d        = ms_q;
    ovf_d       = ovf_q;
    cap_ms_d    = cap_ms_q;
    cap_valid_d = cap_req;

    if (zero_cnt) begin
      ms_d  = '0;
      ovf_d = 1'b0;
    end else if (ms_tick) begin
      if (ms_q == MS_MAX) begin
        ms_d  = HOLD_AT_MAX ? MS_MAX : '0;
        ovf_d = 1'b1;
      end else begin
        ms_d = ms_q + MS_ONE;
      end
    end

    // Capture takes the value present this cycle, before any update.
    if (i_clear) begin
      cap_ms_d = '0;
    end else if (cap_req) begin
      cap_ms_d = ms_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ms_q        <= '0;
      ovf_q       <= 1'b0;
      cap_ms_q    <= '0;
      cap_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ms_q        <= ms_d;
      ovf_q       <= ovf_d;
      cap_ms_q    <= cap_ms_d;
      cap_valid_q <= cap_valid_d;
    end
  end

  assign o_timer_ms  = ms_q;
  assign o_running   = running;
  assign o_ovf       = ovf_q;
  assign o_cap_ms    = cap_ms_q;
  assign o_cap_valid = cap_valid_q;
  assign o_state     = state_q;

endmodule
